// File: rtl/bcd_down_counter_if.sv
// Control/status bundle for bcd_down_counter: load/preset/enable in, count and flags out.
interface bcd_down_counter_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  en;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  done;
  logic                  busy;

  modport master (
    output load, load_val, en,
    input  count, zero, done, busy
  );

  modport slave (
    input  load, load_val, en,
    output count, zero, done, busy
  );
endinterface

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer; all outputs registered, one cycle after the sampling edge, no backpressure.
// Optional BCD_DOWN_AUTORELOAD_EN: on expiry stay in RUN and reload the last preset on the next enable.
module bcd_down_counter #(
  parameter int DIGITS = 2
) (
  input logic              clk,
  input logic              rst,
  bcd_down_counter_if.slave bus
);
  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   count_q, count_nxt;
  logic [W-1:0]   load_san, count_dec;
  logic           zero_q, done_q, done_nxt, busy_q;
`ifdef BCD_DOWN_AUTORELOAD_EN
  logic [W-1:0]   reload_q;
`endif

  always_comb begin : sanitise
    load_san = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_san[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9 : bus.load_val[4*i +: 4];
    end
  end

  // Ripple borrow: every digit below the first nonzero one wraps to 9.
  always_comb begin : decrement
    logic borrow;
    borrow    = 1'b1;
    count_dec = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  always_comb begin : next_state
    state_nxt = state;
    count_nxt = count_q;
    done_nxt  = 1'b0;
    if (bus.load) begin
      count_nxt = load_san;
      state_nxt = (load_san != '0) ? RUN : IDLE;
    end else if (state == RUN && bus.en) begin
      if (count_q > W'(1)) begin
        count_nxt = count_dec;
      end else if (count_q == W'(1)) begin
        count_nxt = '0;
        done_nxt  = 1'b1;
`ifdef BCD_DOWN_AUTORELOAD_EN
        state_nxt = RUN;
`else
        state_nxt = EXPIRED;
`endif
      end else begin
`ifdef BCD_DOWN_AUTORELOAD_EN
        count_nxt = reload_q;
`else
        count_nxt = count_q;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      zero_q  <= (count_nxt == '0);
      done_q  <= done_nxt;
      busy_q  <= (state_nxt == RUN);
    end
  end

`ifdef BCD_DOWN_AUTORELOAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reload_q <= '0;
    end else if (bus.load) begin
      reload_q <= load_san;
    end
  end
`endif

  assign bus.count = count_q;
  assign bus.zero  = zero_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
endmodule

// File: doc/bcd_down_counter.md
# bcd_down_counter

Multi-digit BCD down counter (countdown timer) with parallel load, count enable, and a terminal-count pulse. It is the decrementing counterpart to the team's BCD up counter: it consumes a BCD preset, counts it down to zero in valid BCD, and signals expiry. Typical uses are timeouts, display countdowns, and event-count gating in the lab designs.

## Interface
- `DIGITS`, default 2: number of BCD digits (1–8); count width is 4*DIGITS.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: load `load_val` on this edge; has priority over `en`.
- `load_val`  in  4*DIGITS: BCD preset; digit i is in bits [4i+3:4i].
- `en`  in  1: count enable; one decrement per enabled cycle in RUN.
- `count`  out  4*DIGITS: current BCD value, registered.
- `zero`  out  1: high when `count` equals 0, registered.
- `done`  out  1: one-cycle pulse on the edge where `count` goes from 1 to 0.
- `busy`  out  1: high while in RUN.

## Operation
- Reset values:
  - `count`=0, `zero`=1, `done`=0, `busy`=0.
  - State is IDLE and the reload register is 0.
- Load sanitising: any preset digit greater than 9 is clamped to 9, per digit, before storage. The sanitised value is written to both `count` and the reload register.
- States: IDLE, RUN, EXPIRED.
  - IDLE:
    - `en` is ignored.
    - On `load` with a nonzero sanitised value, go to RUN.
    - On `load` with a value of 0, load it and stay in IDLE; `done` does not fire.
  - RUN:
    - On `load`, reload `count` and stay in RUN; a nonzero value restarts the countdown, and a value of 0 goes to IDLE.
    - Otherwise, on `en` with `count` greater than 1, decrement `count` by 1.
    - Otherwise, on `en` with `count` equal to 1: set `count` to 0, pulse `done`, and go to EXPIRED.
  - EXPIRED:
    - `count` holds 0 and `en` is ignored.
    - `load` behaves as it does in IDLE.
- Decrement arithmetic:
  - Digit 0 decrements; a digit at 0 wraps to 9 and generates a borrow into the next digit.
  - Borrows ripple through the digits combinationally within the same cycle.
  - `count` never holds a non-BCD digit.
- `zero` is derived from the next value of `count` and registered together with it, so the two are always consistent.
- `done` is high for exactly one cycle per expiry and is never asserted while in IDLE.

## Timing
- All outputs are registered, and every effect is visible one cycle after the sampling edge.
- Load latency: `load` sampled at edge k means `count`=preset after edge k.
- Count latency: a preset of N reaches 0 after exactly N enabled RUN cycles, and `done` is high in the cycle after the N-th enable.
- `en` low in RUN holds `count`; gaps in `en` do not alter the total number of enables needed.
- `load` and `en` in the same cycle: load wins and no decrement occurs.
- `rst` has priority over everything and may occur mid-count; the block returns to reset values after the edge.
- Wrap example: with 2 digits, a `count` of 10 followed by `en` gives 09; a `count` of 00 never decrements.

## Configuration
- Macro: `BCD_DOWN_AUTORELOAD_EN`.
- Defined:
  - On `en` in RUN with `count` equal to 1, `count` goes to 0 and `done` pulses, but the state stays RUN.
  - The next `en` at `count` 0 loads the reload register into `count`, with no `done` on that edge.
  - The resulting period is N+1 enables, and `busy` stays high.
  - The reload register updates only on `load`.
- Undefined:
  - EXPIRED behaviour applies as described above.
  - The reload register may be optimised away.

## Test plan
- Reset then load 0x25 with `en` held high:
  - `count` steps 25, 24, …, 20, 19, …, 01, 00.
  - `done` is high for exactly one cycle, after the 25th enable.
  - `busy` falls in the same cycle; `count` then stays at 00 with further `en`.
- Load 0x3A: `count` becomes 0x39, confirming per-digit clamping.
- Load 0x05 and toggle `en` every other cycle: `count` reaches 00 after 5 enables, at around 10 cycles, and `done` pulses once.
- Load 0x40 mid-count, asserted together with `en`: `count` equals 40 on the next cycle with no decrement; a subsequent load of 0x00 gives IDLE and `done` stays 0.
- Assert `rst` at `count`=12 in RUN: the next cycle shows `count`=00, `zero`=1, `busy`=0, `done`=0.
- With `BCD_DOWN_AUTORELOAD_EN`, load 0x03 and hold `en`:
  - `count` cycles 03, 02, 01, 00, 03, 02, …
  - `done` pulses on each 01→00 transition.
  - `busy` stays 1.
